// File: rtl/gate_truth_checker.sv
// gate_truth_checker
// Self-checking partner for the two-input gate block. It walks the gate
// inputs through {a,b} = 00, 01, 10, 11, holds each vector for a settle
// interval, samples the seven gate outputs once and compares them with the
// expected truth table. The results of a run (pass flag, saturating mismatch
// count, failing vectors and failing gates) stay visible in IDLE until the
// next start, so bring-up software can read them at leisure.
//
// Gate output bit order on gate_in:
//   bit0 and, bit1 or, bit2 nand, bit3 nor, bit4 xor, bit5 xnor, bit6 not(a)
//
// SETTLE_CYCLES must be at least 1; ERR_W is expected to be well below 31.

module gate_truth_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       gate_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec,
    output logic [6:0]       fail_mask
);

    // State encoding kept as plain constants so older tools and netlist
    // viewers show stable values.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // The settle counter only needs to reach SETTLE_CYCLES-1.
    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    // Largest value err_count can hold; the count sticks here instead of wrapping.
    localparam int              ERR_MAX_INT = (1 << ERR_W) - 1;
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    logic [1:0]       state;
    logic [1:0]       vec;
    logic [CNT_W-1:0] cnt;

    logic [1:0]       vec_inc;
    logic [6:0]       expected;
    logic [6:0]       mism;
    logic [2:0]       mism_pop;
    int               err_sum;
    logic [ERR_W-1:0] err_next;

    logic             accept;
    logic             settle_end;
    logic             sample_last;
    logic             sample_more;

    // Busy covers every non-idle state, including the single DONE cycle.
    assign busy = (state != ST_IDLE);

    // Decode the handful of events that move the FSM and the registered outputs.
    always_comb begin
        accept      = (state == ST_IDLE) && start;
        settle_end  = (state == ST_DRIVE) && (cnt == CNT_LAST);
        sample_last = (state == ST_SAMPLE) && (vec == 2'd3);
        sample_more = (state == ST_SAMPLE) && (vec != 2'd3);
        vec_inc     = vec + 2'd1;
    end

    // Reference truth table for the vector currently on the gate inputs.
    always_comb begin
        logic a;
        logic b;
        a        = vec[1];
        b        = vec[0];
        expected = {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
        mism     = gate_in ^ expected;
    end

    // Count mismatched gate bits and fold them into the saturating total.
    always_comb begin
        mism_pop = 3'd0;
        for (int i = 0; i < 7; i++) begin
            mism_pop = mism_pop + {2'b00, mism[i]};
        end
        err_sum = int'(err_count) + int'(mism_pop);
        if (err_sum > ERR_MAX_INT) begin
            err_next = ERR_MAX;
        end else begin
            err_next = err_sum[ERR_W-1:0];
        end
    end

    // Sequencer: IDLE -> (DRIVE x SETTLE_CYCLES, SAMPLE) x 4 vectors -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            vec   <= 2'd0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_DRIVE;
                        vec   <= 2'd0;
                        cnt   <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (settle_end) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (sample_last) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_DRIVE;
                        vec   <= vec_inc;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered gate drive: follows the vector index, parked at 00 outside a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out <= 1'b0;
            b_out <= 1'b0;
        end else if (accept || sample_last) begin
            a_out <= 1'b0;
            b_out <= 1'b0;
        end else if (sample_more) begin
            a_out <= vec_inc[1];
            b_out <= vec_inc[0];
        end
    end

    // Result accumulation: cleared when a run is accepted, updated once per SAMPLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
            fail_vec  <= 4'd0;
            fail_mask <= 7'd0;
        end else if (accept) begin
            err_count <= '0;
            fail_vec  <= 4'd0;
            fail_mask <= 7'd0;
        end else if (state == ST_SAMPLE) begin
            err_count <= err_next;
            fail_mask <= fail_mask | mism;
            if (mism != 7'd0) begin
                fail_vec[vec] <= 1'b1;
            end
        end
    end

    // Completion: done pulses for the DONE cycle and pass uses the final count.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (accept) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (sample_last) begin
            done <= 1'b1;
            pass <= (err_next == '0);
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker
// Drives two checker instances (ERR_W=5 and ERR_W=4) against a behavioural
// gate block whose outputs can be corrupted per vector through a flip table.
// Expected results come from the flip table alone: each set bit is one
// mismatched gate bit on that vector.

module tb_gate_truth_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;

    logic       a5, b5, busy5, done5, pass5;
    logic [4:0] err5;
    logic [3:0] fv5;
    logic [6:0] fm5;
    logic [6:0] gate_in5;

    logic       a4, b4, busy4, done4, pass4;
    logic [3:0] err4;
    logic [3:0] fv4;
    logic [6:0] fm4;
    logic [6:0] gate_in4;

    logic [6:0] flip [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Fault-free gate block behaviour, bit order and, or, nand, nor, xor, xnor, not(a).
    function automatic logic [6:0] good_gate(input logic a, input logic b);
        logic [6:0] g;
        g[0] = a && b;
        g[1] = a || b;
        g[2] = !(a && b);
        g[3] = !(a || b);
        g[4] = (a != b);
        g[5] = (a == b);
        g[6] = !a;
        return g;
    endfunction

    assign gate_in5 = good_gate(a5, b5) ^ flip[{a5, b5}];
    assign gate_in4 = good_gate(a4, b4) ^ flip[{a4, b4}];

    gate_truth_checker #(.SETTLE_CYCLES(2), .ERR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gate_in   (gate_in5),
        .a_out     (a5),
        .b_out     (b5),
        .busy      (busy5),
        .done      (done5),
        .pass      (pass5),
        .err_count (err5),
        .fail_vec  (fv5),
        .fail_mask (fm5)
    );

    gate_truth_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gate_in   (gate_in4),
        .a_out     (a4),
        .b_out     (b4),
        .busy      (busy4),
        .done      (done4),
        .pass      (pass4),
        .err_count (err4),
        .fail_vec  (fv4),
        .fail_mask (fm4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected run results derived from the flip table.
    task automatic expectResults(output int e_err, output logic [3:0] e_fv, output logic [6:0] e_fm);
        e_err = 0;
        e_fv  = 4'd0;
        e_fm  = 7'd0;
        for (int v = 0; v < 4; v++) begin
            int n;
            n     = $countones(flip[v]);
            e_err = e_err + n;
            if (n != 0) e_fv[v] = 1'b1;
            e_fm  = e_fm | flip[v];
        end
    endtask

    // One run from IDLE: optional stray start at cycle stray_start, then full result check.
    task automatic applyStimulus(input string tag, input int stray_start);
        int         e_err;
        logic [3:0] e_fv;
        logic [6:0] e_fm;
        int         done_at;
        int         extra_done;
        expectResults(e_err, e_fv, e_fm);
        start = 1'b1;
        tick();
        start   = 1'b0;
        done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            start = (c == stray_start);
            if (done5) begin
                done_at = c;
                break;
            end
            if (c == 1) checkOutput({tag, " busy"}, 32'(busy5), 32'd1);
            if (c <= 12) checkOutput({tag, " ab"}, 32'({a5, b5}), 32'((c - 1) / 3));
            tick();
        end
        start = 1'b0;
        checkOutput({tag, " done_cycle"}, 32'(done_at), 32'd13);
        checkOutput({tag, " done4"}, 32'(done4), 32'd1);
        checkOutput({tag, " ab_done"}, 32'({a5, b5}), 32'd0);
        checkOutput({tag, " pass"}, 32'(pass5), 32'(e_err == 0));
        checkOutput({tag, " err"}, 32'(err5), 32'((e_err > 31) ? 31 : e_err));
        checkOutput({tag, " fail_vec"}, 32'(fv5), 32'(e_fv));
        checkOutput({tag, " fail_mask"}, 32'(fm5), 32'(e_fm));
        checkOutput({tag, " err4"}, 32'(err4), 32'((e_err > 15) ? 15 : e_err));
        checkOutput({tag, " pass4"}, 32'(pass4), 32'(e_err == 0));
        extra_done = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done5) extra_done++;
        end
        checkOutput({tag, " extra_done"}, 32'(extra_done), 32'd0);
        checkOutput({tag, " idle_busy"}, 32'(busy5), 32'd0);
        checkOutput({tag, " held_err"}, 32'(err5), 32'((e_err > 31) ? 31 : e_err));
        checkOutput({tag, " held_pass"}, 32'(pass5), 32'(e_err == 0));
    endtask

    task automatic setFlip(input logic [6:0] f0, input logic [6:0] f1, input logic [6:0] f2, input logic [6:0] f3);
        flip[0] = f0;
        flip[1] = f1;
        flip[2] = f2;
        flip[3] = f3;
    endtask

    initial begin
        int n;
        int dcount;
        rst   = 1'b1;
        start = 1'b0;
        setFlip(7'h00, 7'h00, 7'h00, 7'h00);
        tick();
        tick();
        checkOutput("reset outs", 32'({a5, b5, busy5, done5, pass5}), 32'd0);
        checkOutput("reset err", 32'(err5), 32'd0);
        checkOutput("reset vec_mask", 32'({fv5, fm5}), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("idle busy", 32'(busy5), 32'd0);

        $display("[TB] clean gate block");
        applyStimulus("clean", 0);

        $display("[TB] xor stuck at 0");
        setFlip(7'h00, 7'h10, 7'h10, 7'h00);
        applyStimulus("xor_sa0", 0);
        checkOutput("xor_sa0 fv_const", 32'(fv5), 32'h6);

        $display("[TB] not stuck at 1");
        setFlip(7'h00, 7'h00, 7'h40, 7'h40);
        applyStimulus("not_sa1", 0);
        checkOutput("not_sa1 fv_const", 32'(fv5), 32'hC);

        $display("[TB] all outputs inverted");
        setFlip(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        applyStimulus("inverted", 0);
        checkOutput("inverted err4_const", 32'(err4), 32'd15);

        $display("[TB] clean run with stray start");
        setFlip(7'h00, 7'h00, 7'h00, 7'h00);
        applyStimulus("stray_start", 5);

        $display("[TB] reset mid-run");
        setFlip(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        checkOutput("midrst ab_v2", 32'({a5, b5}), 32'd2);
        checkOutput("midrst err_partial", 32'(err5), 32'd14);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst busy", 32'(busy5), 32'd0);
        checkOutput("midrst ab", 32'({a5, b5}), 32'd0);
        checkOutput("midrst err", 32'(err5), 32'd0);
        checkOutput("midrst vec_mask", 32'({fv5, fm5}), 32'd0);
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            if (done5) dcount++;
            tick();
        end
        checkOutput("midrst no_done", 32'(dcount), 32'd0);
        setFlip(7'h00, 7'h00, 7'h00, 7'h00);
        applyStimulus("after_rst", 0);

        $display("[TB] start held high");
        start = 1'b1;
        n = 0;
        while (!done5 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("b2b first_done", 32'(done5), 32'd1);
        tick();
        checkOutput("b2b idle_gap", 32'(busy5), 32'd0);
        tick();
        checkOutput("b2b restart", 32'(busy5), 32'd1);
        start = 1'b0;
        n = 1;
        while (!done5 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("b2b latency", 32'(n), 32'd13);
        tick();

        $display("[TB] randomized fault tables");
        for (int r = 0; r < 8; r++) begin
            for (int v = 0; v < 4; v++) begin
                if ($urandom_range(0, 2) == 0) flip[v] = 7'h00;
                else flip[v] = 7'($urandom_range(0, 127) & $urandom_range(0, 127));
            end
            applyStimulus("random", (r % 2 == 0) ? 0 : int'($urandom_range(1, 12)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
